// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external multiplexed-bus target.
// Holds the FSM state encoding, bus widths and the excluded I/O window.
package ext_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int AD_W   = 16;

  localparam logic [11:0] IO_BASE_DEFAULT = 12'h1A1;
  localparam logic [2:0]  IO_SUB         = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    DATA,
    CMD,
    ACCESS,
    READY,
    DRAIN
  } state_t;

  // True when the address falls in the on-chip I/O window that this target must ignore.
  function automatic logic in_io_window(input logic [ADDR_W-1:0] addr,
                                        input logic [11:0]       io_base);
    return (addr[31:20] == io_base) && (addr[19:17] == IO_SUB);
  endfunction

endpackage

// File: rtl/ext_bus_addr_decode.sv
// Off-chip window decode: selected when above the low 4 KiB and outside the I/O window.
// Purely combinational so the system bench checker can reuse it as-is.
module ext_bus_addr_decode
  import ext_bus_pkg::*;
#(
  parameter logic [11:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              sel
);

  // The page offset never takes part in the decision.
  logic unused_page_bits;
  assign unused_page_bits = ^addr[11:0];

  assign sel = (addr[31:12] != '0) && !in_io_window(addr, IO_BASE);

endmodule

// File: rtl/ext_bus_responder.sv
// Target side of the MCU multiplexed address/data bus: collects a 32-bit address
// and a data byte, runs one backend byte access and answers with EXT_READY.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int                 TIMEOUT  = 64,
  parameter logic [11:0]        IO_BASE  = IO_BASE_DEFAULT,
  parameter logic [DATA_W-1:0]  ERR_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AE,
  input  logic              EXT_READ,
  input  logic              EXT_WRITE,
  input  logic [AD_W-1:0]   EXT_AD_in,
  output logic [DATA_W-1:0] EXT_AD_out,
  output logic              EXT_AD_oe,
  output logic              EXT_READY,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                is_read;
  logic [CNT_W-1:0]    cnt;
  logic                sel;

  logic                load_lo;
  logic                load_hi;
  logic                load_wdata;
  logic                issue;
  logic                take_rdata;
  logic                time_out;
  logic                flag_err;

  logic                one_strobe;
  logic                both_strobes;
  logic                no_strobe;

  assign one_strobe   = EXT_READ ^ EXT_WRITE;
  assign both_strobes = EXT_READ & EXT_WRITE;
  assign no_strobe    = ~(EXT_READ | EXT_WRITE);

  ext_bus_addr_decode #(
    .IO_BASE (IO_BASE)
  ) u_decode (
    .addr (addr),
    .sel  (sel)
  );

  // NOTE: non-blocking assignments for every register so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    load_wdata = 1'b0;
    issue      = 1'b0;
    take_rdata = 1'b0;
    time_out   = 1'b0;
    flag_err   = 1'b0;

    unique case (state)
      IDLE: begin
        if (AE) begin
          load_lo    = 1'b1;
          state_next = ADDR_HI;
        end
      end

      ADDR_HI: begin
        if (AE) begin
          load_hi    = 1'b1;
          state_next = DATA;
        end else begin
          state_next = IDLE;
        end
      end

      DATA: begin
        if (!AE) begin
          load_wdata = 1'b1;
          state_next = CMD;
        end
      end

      CMD: begin
        // A fresh AE here restarts the address phase with this cycle's low half.
        if (AE) begin
          load_lo    = 1'b1;
          state_next = ADDR_HI;
        end else if (both_strobes) begin
          flag_err   = 1'b1;
          state_next = DRAIN;
        end else if (one_strobe) begin
          if (sel) begin
            issue      = 1'b1;
            state_next = ACCESS;
          end else begin
            state_next = DRAIN;
          end
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          take_rdata = 1'b1;
          state_next = READY;
        end else if (cnt == CNT_LAST) begin
          time_out   = 1'b1;
          flag_err   = 1'b1;
          state_next = READY;
        end
      end

      READY: begin
        if (no_strobe) state_next = IDLE;
      end

      DRAIN: begin
        if (no_strobe) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      is_read   <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      mem_read  <= issue & EXT_READ;
      mem_write <= issue & EXT_WRITE;
      bus_err   <= flag_err;

      if (load_lo)    addr[15:0]  <= EXT_AD_in;
      if (load_hi)    addr[31:16] <= EXT_AD_in;
      if (load_wdata) wdata       <= EXT_AD_in[DATA_W-1:0];

      if (issue) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        is_read   <= EXT_READ;
        cnt       <= '0;
        rdata     <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Late completions after a timeout land outside ACCESS and are never captured.
      if (take_rdata && is_read) rdata <= mem_rdata;
      else if (time_out)         rdata <= ERR_DATA;
    end
  end

  assign EXT_READY  = (state == READY);
  assign EXT_AD_oe  = EXT_READY && is_read;
  assign EXT_AD_out = EXT_AD_oe ? rdata : '0;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Randomized scoreboard bench for ext_bus_responder: a driver pushes expected backend
// requests and bus responses, a monitor pops and compares them as the DUT presents them.
module tb_ext_bus_responder;

  localparam int         TMO     = 8;
  localparam logic [7:0] ERR_VAL = 8'hFF;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    bit         err;
    int         gap;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        AE = 1'b0;
  logic        EXT_READ = 1'b0;
  logic        EXT_WRITE = 1'b0;
  logic [15:0] EXT_AD_in = '0;
  logic [7:0]  EXT_AD_out;
  logic        EXT_AD_oe;
  logic        EXT_READY;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];
  bit   err_q[$];   // 1: timeout (comes with EXT_READY), 0: strobe conflict

  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bk_mem  [logic [31:0]];
  int         next_lat = 1;
  bit         bk_busy  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ext_bus_responder #(
    .TIMEOUT  (TMO),
    .IO_BASE  (12'h1A1),
    .ERR_DATA (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .AE         (AE),
    .EXT_READ   (EXT_READ),
    .EXT_WRITE  (EXT_WRITE),
    .EXT_AD_in  (EXT_AD_in),
    .EXT_AD_out (EXT_AD_out),
    .EXT_AD_oe  (EXT_AD_oe),
    .EXT_READY  (EXT_READY),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Window rule in plain arithmetic: above 4 KiB, and not the 128 KiB I/O block at 0x1A10_0000.
  function automatic bit sel_ref(input logic [31:0] a);
    bit io;
    io = ((a >> 20) == 32'h1A1) && (((a >> 17) & 32'h7) == 0);
    return (a >= 32'h0000_1000) && !io;
  endfunction

  function automatic logic [7:0] init_val(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] bk_rd(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_val(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backend: byte memory answering each request after next_lat cycles (negative = never).
  initial begin
    logic [31:0] ba;
    int          d;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        bk_busy = 1'b1;
        ba      = mem_addr;
        d       = next_lat;
        if (mem_write) bk_mem[ba] = mem_wdata;
        if (d >= 0) begin
          repeat (d) @(posedge clk);
          #1;
          mem_ready = 1'b1;
          mem_rdata = bk_rd(ba);
          @(posedge clk);
          #1;
          mem_ready = 1'b0;
          mem_rdata = 8'($urandom());
        end
        bk_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request, response or error.
  initial begin
    req_t r;
    rsp_t cur;
    bit   have_cur = 1'b0;
    bit   prev_ready = 1'b0;
    bit   prev_err = 1'b0;
    bit   k;
    int   pulse_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_read || mem_write) begin
          check("req_expected", req_q.size() != 0, 1);
          check("req_single", mem_read && mem_write, 0);
          if (req_q.size() != 0) begin
            r = req_q.pop_front();
            check("req_kind", mem_write, r.wr);
            check("req_addr", mem_addr, r.addr);
            if (r.wr) check("req_wdata", mem_wdata, r.wdata);
          end
          pulse_cyc = cyc;
        end
        if (EXT_READY && !prev_ready) begin
          check("rsp_expected", rsp_q.size() != 0, 1);
          have_cur = (rsp_q.size() != 0);
          if (have_cur) begin
            cur = rsp_q.pop_front();
            check("rsp_err", bus_err, cur.err);
            check("rsp_latency", cyc - pulse_cyc, cur.gap);
          end
        end
        if (EXT_READY && have_cur) begin
          check("rsp_oe", EXT_AD_oe, cur.rd);
          check("rsp_data", EXT_AD_out, cur.rd ? cur.data : 8'h00);
        end
        if (!EXT_READY) check("idle_bus", {EXT_AD_oe, EXT_AD_out}, 9'h000);
        if (bus_err) begin
          check("err_expected", err_q.size() != 0, 1);
          check("err_single", prev_err, 0);
          if (err_q.size() != 0) begin
            k = err_q.pop_front();
            check("err_with_ready", EXT_READY, k);
          end
        end
      end
      prev_ready = EXT_READY;
      prev_err   = bus_err;
    end
  end

  task automatic wait_backend();
    for (int n = 0; n < 64; n++) begin
      if (!bk_busy) break;
      @(negedge clk);
    end
    check("backend_idle", bk_busy, 0);
  endtask

  // Drives the address/data phases so the DUT sits in CMD afterwards.
  task automatic addr_phase(input logic [31:0] a, input logic [7:0] wd,
                            input bit abort, input int extra_ae);
    logic [7:0] junk;
    if (abort) begin
      AE = 1'b1; EXT_AD_in = 16'($urandom()); tick();
      EXT_AD_in = 16'($urandom()); tick();
      AE = 1'b0; EXT_AD_in = 16'($urandom()); tick();
    end
    AE = 1'b1; EXT_AD_in = a[15:0];  tick();
    EXT_AD_in = a[31:16]; tick();
    repeat (extra_ae) begin
      EXT_AD_in = 16'($urandom());
      tick();
    end
    AE = 1'b0;
    junk = 8'($urandom());
    EXT_AD_in = {junk, wd};
    tick();
    EXT_AD_in = 16'($urandom());
  endtask

  // op: 0 read, 1 write, 2 both strobes. lat < 0 or >= TMO makes a read time out.
  task automatic bus_txn(input logic [31:0] a, input logic [7:0] wd, input int op,
                         input int lat, input bit abort, input int extra_ae,
                         input int cmd_wait, input int hold);
    bit   s;
    bit   tmo;
    bit   got;
    req_t rq;
    rsp_t rs;
    s   = sel_ref(a);
    tmo = (op == 0) && (lat < 0 || lat >= TMO);
    next_lat = lat;
    addr_phase(a, wd, abort, extra_ae);
    repeat (cmd_wait) tick();
    if (op == 2) begin
      err_q.push_back(1'b0);
    end else if (s) begin
      rq.wr = (op == 1); rq.addr = a; rq.wdata = wd;
      req_q.push_back(rq);
      rs.rd   = (op == 0);
      rs.err  = tmo;
      rs.gap  = tmo ? TMO : lat + 1;
      rs.data = (op == 0) ? (tmo ? ERR_VAL : ref_rd(a)) : 8'h00;
      if (op == 1) ref_mem[a] = wd;
      rsp_q.push_back(rs);
      if (tmo) err_q.push_back(1'b1);
    end
    EXT_READ  = (op != 1);
    EXT_WRITE = (op != 0);
    if (op != 2 && s) begin
      got = 1'b0;
      for (int n = 0; n < 4 * TMO + 16; n++) begin
        @(negedge clk);
        if (EXT_READY) begin
          got = 1'b1;
          break;
        end
      end
      check("ready_seen", got, 1);
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1;
      EXT_READ = 1'b0; EXT_WRITE = 1'b0;
      @(negedge clk);
      check("ready_hold", EXT_READY, 1);
      @(negedge clk);
      check("ready_drop", EXT_READY, 0);
    end else begin
      repeat (hold + 2) tick();
      EXT_READ = 1'b0; EXT_WRITE = 1'b0;
      tick();
    end
    tick();
    wait_backend();
  endtask

  task automatic reset_mid_access(input logic [31:0] a);
    req_t rq;
    bit   got;
    next_lat = 5;
    addr_phase(a, 8'h00, 1'b0, 0);
    rq.wr = 1'b0; rq.addr = a; rq.wdata = 8'h00;
    req_q.push_back(rq);
    EXT_READ = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (mem_read) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_pulse_seen", got, 1);
    @(posedge clk); #1;
    rst = 1'b1; EXT_READ = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {EXT_READY, EXT_AD_oe, EXT_AD_out, mem_read, mem_write, bus_err,
                          mem_addr, mem_wdata}, 64'h0);
    repeat (8) @(negedge clk);
    check("rst_late_ready", {EXT_READY, EXT_AD_oe, mem_read, mem_write, bus_err}, 5'h00);
    wait_backend();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a;
    int          op;
    int          lat;
    int          r;
    pool = '{32'h0000_1000, 32'h0000_1234, 32'h1A12_0000, 32'h1A0F_FFFF,
             32'hFFFF_FFFF, 32'h0001_0000, 32'h1A1F_FFFF, 32'h1A11_FFFF};

    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {EXT_READY, EXT_AD_oe, EXT_AD_out, mem_read, mem_write, bus_err,
                            mem_addr, mem_wdata}, 64'h0);
    rst = 1'b0;
    tick();

    bus_txn(32'h0000_1234, 8'h5A, 1, 3, 1'b0, 0, 0, 0);
    bus_txn(32'h0000_1234, 8'h00, 0, 5, 1'b0, 0, 0, 1);
    bus_txn(32'h1A10_0000, 8'h00, 0, 2, 1'b0, 0, 0, 0);
    bus_txn(32'h0000_0ABC, 8'h00, 0, 2, 1'b0, 0, 1, 0);
    bus_txn(32'h1A12_0000, 8'h00, 0, 2, 1'b0, 1, 0, 0);
    bus_txn(32'h0000_2000, 8'h00, 0, -1, 1'b0, 0, 0, 0);
    bus_txn(32'h0000_2000, 8'h00, 0, TMO + 2, 1'b0, 0, 0, 1);
    bus_txn(32'h0000_2001, 8'h00, 0, TMO - 1, 1'b0, 0, 0, 0);
    bus_txn(32'h0000_3000, 8'h11, 2, 1, 1'b0, 0, 0, 0);
    bus_txn(32'h0000_4444, 8'hC3, 1, 2, 1'b1, 0, 0, 0);
    bus_txn(32'h0000_4444, 8'h00, 0, 1, 1'b0, 0, 0, 0);
    reset_mid_access(32'h0000_5000);
    bus_txn(32'h0000_1234, 8'h00, 0, 1, 1'b0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = {12'h1A1, 3'b000, 17'($urandom())};
      else if (r == 1) a = {20'h00000, 12'($urandom())};
      else if (r == 2) a = $urandom();
      else             a = pool[$urandom_range(0, 7)];
      op = ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1));
      if (op == 0 && $urandom_range(0, 9) == 0)
        lat = ($urandom_range(0, 1) == 0) ? -1 : TMO + 2;
      else
        lat = $urandom_range(1, TMO - 1);
      bus_txn(a, 8'($urandom()), op, lat, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (5) tick();
    check("req_q_drained", req_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- Synthesizable target side of the MCU external multiplexed address/data bus (AE, EXT_AD, EXT_READ, EXT_WRITE, EXT_READY).
- Demultiplexes a 32-bit address over two AE cycles and latches 8-bit write data.
- Decodes the off-chip window, runs one byte access on a simple backend memory port, and answers with EXT_READY and read data.
- Replaces behavioural off-chip glue with RTL for FPGA boards and for the system bench.

Parameters:
- TIMEOUT, 64, backend cycles allowed before the access is force-completed with an error.
- IO_BASE, 12'h1A1, addr[31:20] value of the excluded I/O window (also requires addr[19:17]==3'b000).
- ERR_DATA, 8'hFF, read data returned on timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- AE  in  1  address enable from MCU.
- EXT_READ  in  1  read strobe, level.
- EXT_WRITE  in  1  write strobe, level.
- EXT_AD_in  in  16  sampled multiplexed address/data bus.
- EXT_AD_out  out  8  read data for EXT_AD[7:0].
- EXT_AD_oe  out  1  drive enable for EXT_AD[7:0].
- EXT_READY  out  1  access complete.
- mem_addr  out  32  backend address.
- mem_wdata  out  8  backend write data.
- mem_read  out  1  backend read request, 1-cycle pulse.
- mem_write  out  1  backend write request, 1-cycle pulse.
- mem_rdata  in  8  backend read data, valid with mem_ready.
- mem_ready  in  1  backend completion, 1-cycle pulse.
- bus_err  out  1  1-cycle pulse on timeout or read+write conflict.

Behaviour:
- Reset: state IDLE. All outputs 0: EXT_AD_out=0, EXT_AD_oe=0, EXT_READY=0, mem_*=0, bus_err=0. Latched addr/data cleared. rst mid-transaction aborts at once; no backend pulse is issued afterwards.
- Selection: sel = (addr[31:12] != 0) && !(addr[31:20]==IO_BASE && addr[19:17]==0).
- FSM states and transitions:
  - IDLE: AE=1 -> addr[15:0]<=EXT_AD_in; go ADDR_HI.
  - ADDR_HI: AE=1 -> addr[31:16]<=EXT_AD_in; go DATA. AE=0 -> return to IDLE; the partial address is discarded.
  - DATA: first cycle with AE=0 -> wdata<=EXT_AD_in[7:0]; go CMD. AE still 1 -> stay (extra AE cycles ignored).
  - CMD: waits for a strobe.
    - AE=1 -> abort to ADDR_HI; that cycle's EXT_AD_in is taken as the new addr[15:0].
    - READ and WRITE both 1 -> bus_err pulse, go DRAIN.
    - One strobe and !sel -> go DRAIN silently; EXT_READY is never asserted.
    - One strobe and sel -> one-cycle mem_read or mem_write with mem_addr=addr, mem_wdata=wdata; clear timeout counter; go ACCESS.
  - ACCESS: counts cycles.
    - mem_ready -> capture mem_rdata (reads only); go READY.
    - Counter reaches TIMEOUT-1 without mem_ready -> bus_err pulse, rdata=ERR_DATA; go READY.
    - A late mem_ready after timeout is ignored.
  - READY: EXT_READY=1. For reads, EXT_AD_oe=1 and EXT_AD_out=rdata. Held until both strobes are 0, then all of these deassert next cycle; go IDLE.
  - DRAIN: wait until both strobes are 0, then go IDLE. AE=1 in DRAIN is ignored.
- Latency: strobe seen in CMD to mem pulse is 1 cycle. mem_ready to EXT_READY is 1 cycle. Strobe drop to EXT_READY low is 1 cycle.
- Write data is never driven back onto the bus (EXT_AD_oe stays 0 for writes).

Decomposition:
- Package ext_bus_pkg: FSM state enum (IDLE, ADDR_HI, DATA, CMD, ACCESS, READY, DRAIN); IO window constants; address width 32; data width 8.
- One sub-module ext_bus_addr_decode: combinational sel from the 32-bit address and IO_BASE, shared with the system bench checker.

Test Plan:
- Write: AE cycles 16'h1234 then 16'h0000, data 8'h5A, EXT_WRITE. -> mem_write pulse with mem_addr=32'h0000_1234, mem_wdata=8'h5A; EXT_READY 1 cycle after mem_ready; EXT_AD_oe=0.
- Read: addr 32'h0000_1234, backend returns 8'h5A after 5 cycles. -> EXT_READY=1, EXT_AD_oe=1, EXT_AD_out=8'h5A until EXT_READ drops, then 0 next cycle.
- Unselected: reads of addr 32'h1A10_0000 (I/O window) and 32'h0000_0ABC (addr[31:12]=0). -> no mem pulse, EXT_READY stays 0, FSM returns to IDLE after the strobe drops.
- Timeout: TIMEOUT=8, read 32'h0000_2000, mem_ready never asserted. -> bus_err pulse at cycle 8 of ACCESS, EXT_AD_out=8'hFF with EXT_READY.
- Conflict and abort: both strobes high in CMD -> bus_err, no mem pulse. Separately, AE reasserted in CMD with 16'h4444 -> new transaction with addr[15:0]=16'h4444, old one dropped.
- Reset mid-ACCESS: rst=1 for one cycle. -> all outputs 0 next cycle; a later mem_ready is ignored.
